// File: rtl/i2c_slave_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regfile
// Purpose  : I2C slave serving an 8-bit register file through a pointer byte.
//            Runs entirely on CLK. SCL and SDA are synchronised and
//            glitch-filtered, and START/STOP are decoded in the CLK domain.
//            The pointer auto-increments on every written or transmitted byte.
// Ports    : CLK        system clock (>= 10x SCL)
//            RSTN       asynchronous active-low reset
//            SCL_IN     raw SCL pad level
//            SDA_IN     raw SDA pad level
//            SDA_OE     1 = pull SDA low, 0 = release
//            REGS       flat register file, reg k at [8k+7:8k]
//            WR_STROBE  one-CLK pulse per register write
//            WR_ADDR    index written, valid with WR_STROBE
//            BUSY       high from START to STOP
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         PTR_W       = 4,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      SCL_IN,
  input  logic                      SDA_IN,
  output logic                      SDA_OE,
  output logic [(2**PTR_W)*8-1:0]   REGS,
  output logic                      WR_STROBE,
  output logic [PTR_W-1:0]          WR_ADDR,
  output logic                      BUSY
);

  localparam int NREGS  = 2**PTR_W;
  localparam int FCNT_W = $clog2(FILTER_LEN + 1);

  // --------------------------------------------------------------------------
  // Input path: synchroniser followed by a persistence filter. Index 0 is
  // SCL, index 1 is SDA. Everything resets to 1 so the bus looks idle.
  // --------------------------------------------------------------------------
  logic [1:0] raw_in;
  logic [1:0] filt;

  assign raw_in = {SDA_IN, SCL_IN};

  for (genvar i = 0; i < 2; i++) begin : g_line
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FCNT_W-1:0]      cnt_q;
    logic                   filt_q;

    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        sync_q <= '1;
        cnt_q  <= '0;
        filt_q <= 1'b1;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in[i]};
        // cnt_q counts consecutive samples that disagree with the output;
        // the output flips on the FILTER_LEN-th such sample.
        if (sync_q[SYNC_STAGES-1] == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == FCNT_W'(FILTER_LEN - 1)) begin
          filt_q <= ~filt_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + FCNT_W'(1);
        end
      end
    end

    assign filt[i] = filt_q;
  end

  // --------------------------------------------------------------------------
  // Bus events on the filtered lines
  // --------------------------------------------------------------------------
  logic scl_f, sda_f, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_f = filt[0];
  assign sda_f = filt[1];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise  =  scl_f & ~scl_d;
  assign scl_fall  = ~scl_f &  scl_d;
  // SCL must be high in both samples so an SCL edge is never taken for START/STOP.
  assign start_det =  scl_f &  scl_d &  sda_d & ~sda_f;
  assign stop_det  =  scl_f &  scl_d & ~sda_d &  sda_f;

  // --------------------------------------------------------------------------
  // Protocol FSM
  // --------------------------------------------------------------------------
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR    = 4'd1,
    S_ACK_A   = 4'd2,
    S_PTR     = 4'd3,
    S_ACK_W   = 4'd4,
    S_WR      = 4'd5,
    S_RD      = 4'd6,
    S_RD_ACK  = 4'd7,
    S_RD_NEXT = 4'd8,
    S_IGNORE  = 4'd9
  } state_t;

  state_t           state_q, state_n;
  logic [3:0]       bit_cnt_q, bit_cnt_n;
  logic [7:0]       shift_q, shift_n;
  logic [PTR_W-1:0] ptr, ptr_n;
  logic             sda_oe_q, oe_n;
  logic             busy_q, busy_n;
  logic             wr_stb_q, wr_stb_n;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_n;
  logic             wr_en;
  logic [7:0]       regs_q [NREGS];
  logic [7:0]       rd_byte;
  logic             rx_state, byte_done;

  assign rd_byte   = regs_q[ptr];
  assign rx_state  = (state_q == S_ADDR) || (state_q == S_PTR) || (state_q == S_WR);
  // A received byte is complete once 8 bits are in; its ACK is driven on the next fall.
  assign byte_done = scl_fall && (bit_cnt_q == 4'd8);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr       <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else begin
      state_q   <= state_n;
      bit_cnt_q <= bit_cnt_n;
      shift_q   <= shift_n;
      ptr       <= ptr_n;
      sda_oe_q  <= oe_n;
      busy_q    <= busy_n;
      wr_stb_q  <= wr_stb_n;
      wr_addr_q <= wr_addr_n;
      if (wr_en) regs_q[ptr] <= shift_q;
    end
  end

  always_comb begin
    state_n   = state_q;
    bit_cnt_n = bit_cnt_q;
    shift_n   = shift_q;
    ptr_n     = ptr;
    oe_n      = sda_oe_q;
    busy_n    = busy_q;
    wr_stb_n  = 1'b0;
    wr_addr_n = wr_addr_q;
    wr_en     = 1'b0;

    if (start_det) begin
      state_n   = S_ADDR;
      bit_cnt_n = '0;
      oe_n      = 1'b0;
      busy_n    = 1'b1;
    end else if (stop_det) begin
      state_n = S_IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      if (rx_state && scl_rise && (bit_cnt_q != 4'd8)) begin
        shift_n   = {shift_q[6:0], sda_f};
        bit_cnt_n = bit_cnt_q + 4'd1;
      end

      case (state_q)
        S_ADDR: begin
          if (byte_done) begin
            if (shift_q[7:1] == SLAVE_ADDR) begin
              oe_n    = 1'b1;
              state_n = S_ACK_A;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        S_ACK_A: begin
          // shift_q[0] still holds the R/W bit of the address byte.
          if (scl_fall) begin
            if (shift_q[0]) begin
              shift_n   = rd_byte;
              oe_n      = ~rd_byte[7];
              bit_cnt_n = 4'd1;
              state_n   = S_RD;
            end else begin
              oe_n      = 1'b0;
              bit_cnt_n = '0;
              state_n   = S_PTR;
            end
          end
        end
        S_PTR: begin
          if (byte_done) begin
            ptr_n   = shift_q[PTR_W-1:0];
            oe_n    = 1'b1;
            state_n = S_ACK_W;
          end
        end
        S_ACK_W: begin
          if (scl_fall) begin
            oe_n      = 1'b0;
            bit_cnt_n = '0;
            state_n   = S_WR;
          end
        end
        S_WR: begin
          if (byte_done) begin
            wr_en     = 1'b1;
            wr_stb_n  = 1'b1;
            wr_addr_n = ptr;
            ptr_n     = ptr + PTR_W'(1);
            oe_n      = 1'b1;
            state_n   = S_ACK_W;
          end
        end
        S_RD: begin
          // bit_cnt_q counts bits already placed on the bus.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              oe_n    = 1'b0;
              ptr_n   = ptr + PTR_W'(1);
              state_n = S_RD_ACK;
            end else begin
              shift_n   = {shift_q[6:0], 1'b0};
              oe_n      = ~shift_q[6];
              bit_cnt_n = bit_cnt_q + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            state_n = sda_f ? S_IGNORE : S_RD_NEXT;
          end
        end
        S_RD_NEXT: begin
          if (scl_fall) begin
            shift_n   = rd_byte;
            oe_n      = ~rd_byte[7];
            bit_cnt_n = 4'd1;
            state_n   = S_RD;
          end
        end
        S_IGNORE: begin
          oe_n = 1'b0;
        end
        default: begin
          state_n = S_IDLE;
          oe_n    = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NREGS; k++) begin : g_flat
    assign REGS[8*k +: 8] = regs_q[k];
  end

  assign SDA_OE    = sda_oe_q;
  assign WR_STROBE = wr_stb_q;
  assign WR_ADDR   = wr_addr_q;
  assign BUSY      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_regfile
// Purpose  : Self-checking bench for i2c_slave_regfile. A bus master drives
//            SCL/SDA (open-drain wired-AND with the slave's SDA_OE), and a
//            transaction-level register/pointer model predicts ACKs, read data,
//            write strobes and the idle register contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regfile;

  logic         clk;
  logic         rstn;
  logic         scl;
  logic         sda_m;
  logic         sda_line;
  logic         sda_oe;
  logic [127:0] regs;
  logic         wr_strobe;
  logic [3:0]   wr_addr;
  logic         busy;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_regfile #(
    .SLAVE_ADDR (7'h42),
    .PTR_W      (4),
    .SYNC_STAGES(2),
    .FILTER_LEN (3)
  ) dut (
    .CLK       (clk),
    .RSTN      (rstn),
    .SCL_IN    (scl),
    .SDA_IN    (sda_line),
    .SDA_OE    (sda_oe),
    .REGS      (regs),
    .WR_STROBE (wr_strobe),
    .WR_ADDR   (wr_addr),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [7:0] m_regs [16];
  int         m_ptr;
  bit         m_match, m_first;
  logic [3:0] exp_wr [$];
  logic [3:0] wr_log [$];

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int k = 0; k < 16; k++) f[8*k +: 8] = m_regs[k];
    return f;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 16; k++) m_regs[k] = 8'h00;
    m_ptr = 0;
  endtask

  // ---------------- compare / monitor process ----------------
  bit   cmp_en  = 0;
  bit   oe_seen = 0;
  logic oe_q    = 1'b0;
  logic rstn_q  = 1'b0;
  logic stb_q   = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("idle_regs", regs, model_flat());
      chk("idle_busy", busy, 1'b0);
      chk("idle_oe", sda_oe, 1'b0);
      chk("idle_strobe", wr_strobe, 1'b0);
    end
    // The slave may only move SDA while SCL is low.
    if (rstn && rstn_q && (sda_oe !== oe_q)) chk("oe_change_scl_low", scl, 1'b0);
    if (wr_strobe) begin
      wr_log.push_back(wr_addr);
      chk("strobe_one_clk", stb_q, 1'b0);
    end
    if (sda_oe) oe_seen = 1;
    oe_q   <= sda_oe;
    rstn_q <= rstn;
    stb_q  <= wr_strobe;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- bus master ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    tick(5); sda_m = b; tick(5); scl = 1'b1;
    if (glitch) begin
      tick(3); scl = 1'b0; tick(2); scl = 1'b1; tick(5);
    end else begin
      tick(10);
    end
    scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    tick(5); sda_m = 1'b1; tick(5); scl = 1'b1;
    tick(5); b = sda_line; tick(5); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch);
    recv_bit(a);
    ack = ~a;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    for (int i = 7; i >= 0; i--) recv_bit(b[i]);
    send_bit(nack, 1'b0);
  endtask

  task automatic bus_start();
    cmp_en = 0;
    if (scl == 1'b0) begin
      tick(5); sda_m = 1'b1; tick(5); scl = 1'b1; tick(10);
    end
    sda_m = 1'b0; tick(10); scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(5); sda_m = 1'b0; tick(5); scl = 1'b1; tick(10); sda_m = 1'b1;
    tick(12);
    cmp_en = 1;
  endtask

  task automatic mst_addr(input logic [7:0] a, input int glitch);
    logic ack;
    write_byte(a, glitch, ack);
    m_match = (a[7:1] == 7'h42);
    m_first = 1;
    chk("addr_ack", ack, m_match);
    chk("busy_mid", busy, 1'b1);
  endtask

  task automatic mst_wr(input logic [7:0] b);
    logic ack;
    write_byte(b, -1, ack);
    chk("wr_ack", ack, m_match);
    if (m_match) begin
      if (m_first) begin
        m_ptr = int'(b[3:0]);
      end else begin
        m_regs[m_ptr] = b;
        exp_wr.push_back(4'(m_ptr));
        m_ptr = (m_ptr + 1) % 16;
      end
    end
    m_first = 0;
  endtask

  task automatic mst_rd(input logic nack, output logic [7:0] got);
    read_byte(got, nack);
    chk("rd_data", got, m_regs[m_ptr]);
    m_ptr = (m_ptr + 1) % 16;
  endtask

  task automatic check_wr_log(input string tag);
    chk({tag, "_wr_count"}, 128'(wr_log.size()), 128'(exp_wr.size()));
    for (int k = 0; k < exp_wr.size() && k < wr_log.size(); k++)
      chk({tag, "_wr_addr"}, wr_log[k], exp_wr[k]);
    wr_log.delete();
    exp_wr.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] d0, d1, d2;
    logic [3:0] bits;
    logic [7:0] abyte;

    rstn = 1'b0; scl = 1'b1; sda_m = 1'b1;
    model_clear();
    tick(3);
    chk("rst_oe", sda_oe, 1'b0);
    chk("rst_strobe", wr_strobe, 1'b0);
    chk("rst_wr_addr", wr_addr, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_regs", regs, 128'h0);
    chk("rst_ptr", dut.ptr, 4'h0);
    rstn = 1'b1;
    tick(20);
    cmp_en = 1;
    tick(5);

    // Write two registers through the pointer
    bus_start(); mst_addr(8'h84, -1);
    mst_wr(8'h03); mst_wr(8'hA5); mst_wr(8'h5A);
    bus_stop();
    chk("t1_reg3", regs[31:24], 8'hA5);
    chk("t1_reg4", regs[39:32], 8'h5A);
    chk("t1_ptr", dut.ptr, 4'd5);
    chk("t1_nstrobe", 128'(wr_log.size()), 128'd2);
    chk("t1_stb0", wr_log[0], 4'd3);
    chk("t1_stb1", wr_log[1], 4'd4);
    check_wr_log("t1");

    // Fill 14, 15 and (after wrap) 0
    bus_start(); mst_addr(8'h84, -1);
    mst_wr(8'h0E); mst_wr(8'h11); mst_wr(8'h22); mst_wr(8'h33);
    bus_stop();
    chk("t2w_reg0", regs[7:0], 8'h33);
    check_wr_log("t2w");

    // Random read with repeated START, wrapping from 15 to 0
    bus_start(); mst_addr(8'h84, -1); mst_wr(8'h0E);
    bus_start(); mst_addr(8'h85, -1);
    mst_rd(1'b0, d0); mst_rd(1'b0, d1); mst_rd(1'b1, d2);
    bus_stop();
    chk("t2_d0", d0, 8'h11);
    chk("t2_d1", d1, 8'h22);
    chk("t2_d2", d2, 8'h33);
    chk("t2_ptr", dut.ptr, 4'd1);
    check_wr_log("t2r");

    // Wrong address: no ACK, no write
    oe_seen = 0;
    bus_start(); mst_addr(8'h90, -1); mst_wr(8'h11);
    bus_stop();
    chk("t3_oe_never", oe_seen, 1'b0);
    chk("t3_busy_end", busy, 1'b0);
    check_wr_log("t3");

    // Two-CLK SCL glitch in the address byte is filtered out
    bus_start(); mst_addr(8'h84, 4);
    mst_wr(8'h07); mst_wr(8'h5A);
    bus_stop();
    chk("t4_reg7", regs[63:56], 8'h5A);
    check_wr_log("t4");

    // Pointer-only write
    bus_start(); mst_addr(8'h84, -1); mst_wr(8'h07);
    bus_stop();
    chk("t5_ptr_only", dut.ptr, 4'd7);
    check_wr_log("t5p");

    // STOP after four bits of a read byte (reg7 = 0x5A, fifth bit is 1)
    bus_start(); mst_addr(8'h85, -1);
    for (int i = 3; i >= 0; i--) recv_bit(bits[i]);
    bus_stop();
    chk("t5_bits", bits, 4'b0101);
    chk("t5_oe_after_stop", sda_oe, 1'b0);
    chk("t5_busy_after_stop", busy, 1'b0);

    // Next transfer behaves normally
    bus_start(); mst_addr(8'h84, -1); mst_wr(8'h09); mst_wr(8'h77);
    bus_stop();
    bus_start(); mst_addr(8'h84, -1); mst_wr(8'h09);
    bus_start(); mst_addr(8'h85, -1); mst_rd(1'b1, d0);
    bus_stop();
    chk("t5_recover", d0, 8'h77);
    check_wr_log("t5r");

    // Reset while the slave is ACKing its address
    bus_start();
    abyte = 8'h84;
    for (int i = 7; i >= 0; i--) send_bit(abyte[i], 1'b0);
    tick(8);
    chk("t6_ack_before_reset", sda_oe, 1'b1);
    rstn = 1'b0;
    #1;
    chk("t6_oe", sda_oe, 1'b0);
    chk("t6_regs", regs, 128'h0);
    chk("t6_ptr", dut.ptr, 4'h0);
    chk("t6_busy", busy, 1'b0);
    model_clear();
    tick(3);
    rstn = 1'b1;
    sda_m = 1'b1;
    tick(5); scl = 1'b1; tick(20);
    cmp_en = 1;
    tick(5);

    bus_start(); mst_addr(8'h84, -1); mst_wr(8'h02); mst_wr(8'h9C);
    bus_stop();
    bus_start(); mst_addr(8'h84, -1); mst_wr(8'h02);
    bus_start(); mst_addr(8'h85, -1); mst_rd(1'b1, d0);
    bus_stop();
    chk("t6_recover", d0, 8'h9C);
    check_wr_log("t6");

    tick(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
